// File: rtl/writeback_select.sv
// Writeback source selector with load extraction and a one-deep output register.
// Picks one of NUM_SRC candidate values and, for the memory source, extracts
// a byte, half or word. The result is held under a valid/ready handshake.
// Unsupported selects and misaligned or unknown load modes raise a sticky error.
module writeback_select #(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 4,
  parameter int MEM_IDX  = 1,
  parameter int LOAD_EXT = 1,
  // Defaults to the minimum width. It may be widened so that out-of-range
  // selects can be presented to the block.
  parameter int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic [2:0]               load_mode,
  input  logic [1:0]               byte_off,
  input  logic                     reg_write,
  input  logic [4:0]               dest_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         wb_data,
  output logic [4:0]               wb_dest,
  output logic                     wb_en,
  output logic                     sel_err
);

  localparam logic [2:0] LM_WORD   = 3'b000;
  localparam logic [2:0] LM_BYTE_S = 3'b001;
  localparam logic [2:0] LM_BYTE_U = 3'b010;
  localparam logic [2:0] LM_HALF_S = 3'b011;
  localparam logic [2:0] LM_HALF_U = 3'b100;

  logic             accept;
  logic             wb_we;
  logic [WIDTH-1:0] cand;
  logic             sel_oob;
  logic             sel_mem;
  logic [31:0]      mem_word;
  logic [7:0]       byte_val;
  logic [15:0]      half_val;
  logic [31:0]      ext_val;
  logic             mode_err;
  logic [WIDTH-1:0] next_data;
  logic             next_err;

  // A new request fits when the register is empty or is being drained now.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Register 0 is hard-wired to zero, so it never receives a write strobe.
  assign wb_en    = out_valid && wb_we && (wb_dest != 5'd0);

  // Candidate mux: a loop over real sources avoids any out-of-range part-select.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand    = '0;
    sel_oob = 1'b1;
    sel_mem = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        cand    = src_data[k*WIDTH +: WIDTH];
        sel_oob = 1'b0;
        sel_mem = (k == MEM_IDX);
      end
    end
  end

  // Load extraction on a 32-bit view of the memory word.
  always_comb begin
    mem_word = 32'(cand);
    byte_val = mem_word[8*byte_off +: 8];
    half_val = mem_word[16*byte_off[1] +: 16];
    ext_val  = mem_word;
    mode_err = 1'b0;
    case (load_mode)
      LM_BYTE_S: ext_val = {{24{byte_val[7]}}, byte_val};
      LM_BYTE_U: ext_val = {24'd0, byte_val};
      LM_HALF_S: begin
        ext_val  = {{16{half_val[15]}}, half_val};
        mode_err = byte_off[0];
      end
      LM_HALF_U: begin
        ext_val  = {16'd0, half_val};
        mode_err = byte_off[0];
      end
      LM_WORD:   mode_err = (byte_off != 2'd0);
      default:   mode_err = 1'b1;
    endcase
  end

  // Final value and error for the request currently presented.
  always_comb begin
    next_data = cand;
    next_err  = 1'b0;
    if (sel_oob) begin
      next_data = '0;
      next_err  = 1'b1;
    end else if (sel_mem && (LOAD_EXT != 0)) begin
      next_data = WIDTH'(ext_val);
      next_err  = mode_err;
    end
  end

  // Output register, handshake state and sticky error; reset discards any held result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid <= 1'b0;
      wb_data   <= '0;
      wb_dest   <= 5'd0;
      wb_we     <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        wb_data   <= next_data;
        wb_dest   <= dest_in;
        wb_we     <= reg_write;
        if (next_err) sel_err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_select.sv
// Self-checking bench for writeback_select: directed scenarios then random traffic,
// all compared against a transaction-level reference model.
module tb_writeback_select;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         sel;
  logic [2:0]               load_mode;
  logic [1:0]               byte_off;
  logic                     reg_write;
  logic [4:0]               dest_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         wb_data;
  logic [4:0]               wb_dest;
  logic                     wb_en;
  logic                     sel_err;

  writeback_select #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .MEM_IDX(1), .LOAD_EXT(1), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .sel(sel), .load_mode(load_mode), .byte_off(byte_off),
    .reg_write(reg_write), .dest_in(dest_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_dest(wb_dest), .wb_en(wb_en),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what the output register should hold.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [4:0]  m_dest  = '0;
  logic        m_we    = 1'b0;
  logic        m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {err, data} for one request, derived arithmetically from the load rules.
  function automatic logic [32:0] ref_result(input logic [127:0] src, input int s,
                                             input int mode, input int off);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    if (s >= NUM_SRC) return {1'b1, 32'd0};
    w = src[s*32 +: 32];
    if (s != 1) return {1'b0, w};
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (mode)
      1: return {1'b0, (b > 127) ? b + 32'hFFFF_FF00 : b};
      2: return {1'b0, b};
      3: return {off % 2 == 1, (h > 32767) ? h + 32'hFFFF_0000 : h};
      4: return {off % 2 == 1, h};
      0: return {off != 0, w};
      default: return {1'b1, w};
    endcase
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    logic        exp_ready;
    logic        acc;
    logic [32:0] r;
    #1;
    exp_ready = !m_valid || out_ready;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = in_valid && exp_ready;
    r   = ref_result(src_data, int'(sel), int'(load_mode), int'(byte_off));
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_dest = '0; m_we = 1'b0; m_err = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_data = r[31:0]; m_dest = dest_in; m_we = reg_write;
      m_err   = m_err | r[32];
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("wb_data", wb_data, m_data);
    check("wb_dest", 32'(wb_dest), 32'(m_dest));
    check("wb_en", 32'(wb_en), 32'(m_valid && m_we && m_dest != 5'd0));
    check("sel_err", 32'(sel_err), 32'(m_err));
  endtask

  task automatic set_req(input int s, input logic [31:0] val, input int mode, input int off,
                         input logic rw, input int dst);
    src_data[s*32 +: 32] = val;
    sel       = SEL_W'(s);
    load_mode = 3'(mode);
    byte_off  = 2'(off);
    reg_write = rw;
    dest_in   = 5'(dst);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src_data = '0; sel = '0; load_mode = '0; byte_off = '0; reg_write = 1'b0; dest_in = '0;

    // Reset state
    cycle();
    reset = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_wb_en", 32'(wb_en), 32'd0);

    // ALU path
    in_valid = 1'b1;
    set_req(0, 32'h0000_1234, 0, 0, 1'b1, 8);
    cycle();
    check("alu_data", wb_data, 32'h0000_1234);
    check("alu_dest", 32'(wb_dest), 32'd8);
    check("alu_wb_en", 32'(wb_en), 32'd1);

    // Byte loads
    set_req(1, 32'h80FF_7F01, 1, 3, 1'b1, 9);
    cycle();
    check("lb_signed", wb_data, 32'hFFFF_FF80);
    set_req(1, 32'h80FF_7F01, 2, 1, 1'b1, 9);
    cycle();
    check("lbu", wb_data, 32'h0000_007F);
    check("lbu_no_err", 32'(sel_err), 32'd0);

    // Half loads, aligned then misaligned
    set_req(1, 32'h8001_1234, 3, 2, 1'b1, 10);
    cycle();
    check("lh_signed", wb_data, 32'hFFFF_8001);
    set_req(1, 32'h8001_1234, 3, 1, 1'b1, 10);
    cycle();
    check("lh_misaligned_data", wb_data, 32'h0000_1234);
    check("lh_misaligned_err", 32'(sel_err), 32'd1);

    // Mode and offset ignored off the memory source
    reset = 1'b1; in_valid = 1'b0;
    cycle();
    reset = 1'b0; in_valid = 1'b1;
    set_req(2, 32'hCAFE_0004, 7, 3, 1'b1, 3);
    cycle();
    check("non_mem_ignores_mode", 32'(sel_err), 32'd0);

    // Backpressure: hold for 3 cycles, then accept and consume on the same edge
    set_req(0, 32'h0000_AAAA, 0, 0, 1'b1, 4);
    cycle();
    out_ready = 1'b0;
    set_req(0, 32'h0000_BBBB, 0, 0, 1'b1, 5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_data", wb_data, 32'h0000_AAAA);
    end
    out_ready = 1'b1;
    cycle();
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_data", wb_data, 32'h0000_BBBB);

    // dest 0 never writes
    set_req(0, 32'h1111_1111, 0, 0, 1'b1, 0);
    cycle();
    check("dest0_wb_en", 32'(wb_en), 32'd0);

    // Out-of-range select, sticky error
    sel = 3'd5; dest_in = 5'd6;
    cycle();
    check("oob_data", wb_data, 32'd0);
    check("oob_err", 32'(sel_err), 32'd1);
    set_req(0, 32'h2222_2222, 0, 0, 1'b1, 6);
    cycle();
    cycle();
    check("err_sticky", 32'(sel_err), 32'd1);

    // Non-accepted bad request must not raise the error
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    out_ready = 1'b0;
    set_req(0, 32'h3333_3333, 0, 0, 1'b1, 7);
    cycle();
    sel = 3'd6;
    cycle();
    check("blocked_no_err", 32'(sel_err), 32'd0);

    // Reset mid-stall discards the held result
    reset = 1'b1;
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    check("midstall_valid", 32'(out_valid), 32'd0);
    check("midstall_err", 32'(sel_err), 32'd0);
    check("midstall_in_ready", 32'(in_ready), 32'd1);
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NUM_SRC; k++) src_data[k*32 +: 32] = $urandom;
      sel       = ($urandom_range(0, 15) == 0) ? SEL_W'($urandom_range(4, 7))
                                               : SEL_W'($urandom_range(0, 3));
      load_mode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                              : 3'($urandom_range(0, 4));
      byte_off  = 2'($urandom_range(0, 3));
      reg_write = 1'($urandom_range(0, 1));
      dest_in   = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_select.md
WRITEBACK_SELECT -- requirements
Module: writeback_select

Interface
REQ-001 Parameter WIDTH, default 32, data width of every source and of wb_data.
REQ-002 Parameter NUM_SRC, default 4, number of candidate sources: 0 = ALU result, 1 = memory read data, 2 = PC+4, 3 = upper immediate.
REQ-003 Parameter MEM_IDX, default 1, the source index to which load extraction applies.
REQ-004 Parameter LOAD_EXT, default 1; when 0, the MEM_IDX source passes through unmodified and WIDTH may be any value >= 1; when 1, WIDTH SHALL be 32.
REQ-005 Derived SEL_W = max(1, clog2(NUM_SRC)).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  upstream presents a writeback request.
REQ-009 in_ready  output  1  block can accept a request this cycle.
REQ-010 src_data  input  NUM_SRC*WIDTH  concatenated sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-011 sel  input  SEL_W  source select.
REQ-012 load_mode  input  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned.
REQ-013 byte_off  input  2  address bits [1:0] of the load.
REQ-014 reg_write  input  1  request writes the register file.
REQ-015 dest_in  input  5  destination register number.
REQ-016 out_valid  output  1  registered result is held.
REQ-017 out_ready  input  1  downstream consumes the result this cycle.
REQ-018 wb_data  output  WIDTH  registered writeback value.
REQ-019 wb_dest  output  5  registered destination.
REQ-020 wb_en  output  1  register-file write strobe.
REQ-021 sel_err  output  1  sticky error flag.

Function
REQ-022 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-023 Accept occurs on the edge where in_valid && in_ready; on accept, wb_data, wb_dest and the stored reg_write SHALL load and out_valid SHALL become 1, so latency is 1 cycle.
REQ-024 On the edge where out_valid && out_ready and no accept occurs, out_valid SHALL become 0.
REQ-025 While out_valid && !out_ready, wb_data, wb_dest and wb_en SHALL hold stable.
REQ-026 Accept and consume on the same edge SHALL load the new request with out_valid remaining 1, giving full throughput.
REQ-027 If sel < NUM_SRC and sel != MEM_IDX, the loaded value SHALL be source[sel].
REQ-028 If sel == MEM_IDX and LOAD_EXT=1, the loaded value SHALL be extracted from the memory word m as follows:
- Byte modes: take m[8*byte_off +: 8], sign-extended (001) or zero-extended (010).
- Half modes: take m[16*byte_off[1] +: 16], sign-extended (011) or zero-extended (100).
- Word mode: take m unshifted.
REQ-029 If sel >= NUM_SRC, the loaded value SHALL be 0 and sel_err SHALL set on accept.
REQ-030 Each of the following SHALL set sel_err on accept, with data extracted as defined above:
- load_mode 101, 110 or 111, treated as word;
- half mode with byte_off[0] = 1;
- word mode with byte_off != 0.
REQ-031 load_mode and byte_off SHALL be ignored when sel != MEM_IDX or LOAD_EXT=0.
REQ-032 wb_en SHALL equal out_valid && stored reg_write && (wb_dest != 0); register 0 is never written.
REQ-033 sel_err SHALL remain 1 until reset, and SHALL never be set by a non-accepted request.

Reset
REQ-034 While reset is high on an edge, the following SHALL be forced and no accept SHALL occur:
- out_valid = 0, wb_data = 0, wb_dest = 0, stored reg_write = 0, sel_err = 0;
- consequently in_ready = 1 and wb_en = 0 in the cycle after.
REQ-035 Reset asserted while out_valid && !out_ready SHALL discard the held result.

Verification
REQ-036 ALU path: sel=0, src0=0x0000_1234, reg_write=1, dest=8, out_ready=1 -> next cycle wb_data=0x0000_1234, wb_dest=8, wb_en=1.
REQ-037 Signed byte load: sel=1, m=0x80FF_7F01, load_mode=001, byte_off=3 -> wb_data=0xFFFF_FF80; byte_off=1, load_mode=010 -> 0x0000_007F.
REQ-038 Half loads: m=0x8001_1234, load_mode=011, byte_off=2 -> 0xFFFF_8001; byte_off=1 -> sel_err=1, data 0x0000_1234.
REQ-039 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and wb_data stable; then out_ready=1 -> new request accepted that same edge, out_valid stays 1.
REQ-040 Edge cases: dest=0 with reg_write=1 -> wb_en=0; sel=5 with NUM_SRC=4 and SEL_W=3 -> wb_data=0, sel_err=1 sticky until reset.
REQ-041 Reset mid-stall: out_valid=1, out_ready=0, reset pulsed -> out_valid=0, sel_err=0, in_ready=1 the next cycle.
